// File: rtl/queue_packet_deframer_if.sv
// Bundle of the byte-queue read port, header report and packed-word stream
// between the queue deframer (master) and its queue/core neighbours (slave).
interface queue_packet_deframer_if;
  logic        q_valid;
  logic [7:0]  q_data;
  logic        q_insert;
  logic        q_read;
  logic        hdr_valid;
  logic [1:0]  hdr_type;
  logic [5:0]  hdr_len;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [2:0]  m_bytes;
  logic        m_last;

  modport master (
    input  q_valid, q_data, q_insert, m_ready,
    output q_read, hdr_valid, hdr_type, hdr_len,
           m_valid, m_data, m_bytes, m_last
  );

  modport slave (
    output q_valid, q_data, q_insert, m_ready,
    input  q_read, hdr_valid, hdr_type, hdr_len,
           m_valid, m_data, m_bytes, m_last
  );
endinterface

// File: rtl/queue_packet_deframer.sv
// Pops length-prefixed packets from the SRAM byte queue and repacks each
// payload into little-endian 32-bit words on a valid/ready stream.
module queue_packet_deframer #(
  parameter int SETTLE = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  queue_packet_deframer_if.master   bus
);

  typedef enum logic [1:0] {HDR, PAY, EMIT} state_t;

  localparam logic [1:0] SETTLE_LD = 2'(SETTLE);

  state_t      state;
  logic [1:0]  settle;
  logic [5:0]  k;
  logic        pop;

  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    w[{lane, 3'b000} +: 8] = b;
    return w;
  endfunction

  // A read is ignored by the queue during an insert, so the pop is deferred.
  assign pop = !rst && (settle == 2'd0) && bus.q_valid && !bus.q_insert &&
               !bus.m_valid && (state != EMIT);

  assign bus.q_read = pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HDR;
      k             <= 6'd0;
      settle        <= SETTLE_LD;
      bus.hdr_valid <= 1'b0;
      bus.hdr_type  <= 2'd0;
      bus.hdr_len   <= 6'd0;
      bus.m_valid   <= 1'b0;
      bus.m_data    <= 32'd0;
      bus.m_bytes   <= 3'd0;
      bus.m_last    <= 1'b0;
    end else begin
      bus.hdr_valid <= 1'b0;

      // Keeps counting through EMIT so a long stall absorbs the SRAM settle.
      if (pop)
        settle <= SETTLE_LD;
      else if (settle != 2'd0)
        settle <= settle - 2'd1;

      case (state)
        HDR: begin
          if (pop) begin
            bus.hdr_valid <= 1'b1;
            bus.hdr_type  <= bus.q_data[7:6];
            bus.hdr_len   <= bus.q_data[5:0];
            k             <= 6'd0;
            if (bus.q_data[5:0] == 6'd0) begin
              state       <= EMIT;
              bus.m_valid <= 1'b1;
              bus.m_data  <= 32'd0;
              bus.m_bytes <= 3'd0;
              bus.m_last  <= 1'b1;
            end else begin
              state <= PAY;
            end
          end
        end

        PAY: begin
          if (pop) begin
            bus.m_data <= put_byte(bus.m_data, k[1:0], bus.q_data);
            k          <= k + 6'd1;
            if ((k[1:0] == 2'd3) || (k + 6'd1 == bus.hdr_len)) begin
              state       <= EMIT;
              bus.m_valid <= 1'b1;
              bus.m_bytes <= {1'b0, k[1:0]} + 3'd1;
              bus.m_last  <= (k + 6'd1 == bus.hdr_len);
            end
          end
        end

        EMIT: begin
          if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
            bus.m_data  <= 32'd0;
            bus.m_bytes <= 3'd0;
            bus.m_last  <= 1'b0;
            state       <= bus.m_last ? HDR : PAY;
          end
        end

        default: state <= HDR;
      endcase
    end
  end

endmodule
